// File: rtl/jkff_bank_if.sv
// Control and status bundle for the jkff_bank state-element bank.
// The driver side owns the lane inputs; the bank side owns state and flags.
interface jkff_bank_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             err_clr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_n;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [CNT_W-1:0] toggle_cnt;
    logic             sr_err;

    modport master (
        output en, mode, j, k, err_clr,
        input  q, q_n, rise, fall, toggle_cnt, sr_err
    );

    modport slave (
        input  en, mode, j, k, err_clr,
        output q, q_n, rise, fall, toggle_cnt, sr_err
    );
endinterface

// File: rtl/jkff_bank.sv
// Multi-lane JK/T/D/SR flip-flop bank with edge flags, a saturating
// transition counter and a sticky SR-illegal error flag.
module jkff_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 16
) (
    input logic        clk,
    input logic        rst,
    jkff_bank_if.slave bus
);
    localparam int SUM_W = CNT_W + 7;
    localparam logic [SUM_W-1:0] CNT_MAX = {{7{1'b0}}, {CNT_W{1'b1}}};

    generate
        if (WIDTH < 1 || WIDTH > 64 || CNT_W < 2 || CNT_W > 32) begin : g_bad_param
            $error("jkff_bank: WIDTH must be 1..64 and CNT_W 2..32");
        end
    endgenerate

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_sr_set;
    logic [WIDTH-1:0] w_sr_clr;
    logic             w_err_set;
    logic [6:0]       w_pop;
    logic [SUM_W-1:0] w_sum;
    logic [CNT_W-1:0] w_cnt_next;

    assign w_sr_set = bus.j & ~bus.k;
    assign w_sr_clr = bus.k & ~bus.j;

    always_comb begin
        w_q_next  = r_q;
        w_err_set = 1'b0;
        if (bus.en) begin
            unique case (bus.mode)
                2'b00: w_q_next = (~r_q & bus.j) | (r_q & ~bus.k);
                2'b01: w_q_next = r_q ^ bus.j;
                2'b10: w_q_next = bus.j;
                2'b11: begin
                    // S=R=1 falls through both masks, so the lane holds
                    w_q_next  = w_sr_set | (r_q & ~w_sr_clr);
                    w_err_set = |(bus.j & bus.k);
                end
            endcase
        end
    end

    assign w_diff = r_q ^ w_q_next;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + 7'(w_diff[i]);
        end
    end

    assign w_sum      = {7'b0, r_cnt} + {{(SUM_W-7){1'b0}}, w_pop};
    assign w_cnt_next = (w_sum > CNT_MAX) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= RESET_VAL;
            r_rise <= '0;
            r_fall <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_rise <= ~r_q & w_q_next;
            r_fall <= r_q & ~w_q_next;
            r_cnt  <= w_cnt_next;
            r_err  <= w_err_set | (r_err & ~bus.err_clr);
        end
    end

    assign bus.q          = r_q;
    assign bus.q_n        = ~r_q;
    assign bus.rise       = r_rise;
    assign bus.fall       = r_fall;
    assign bus.toggle_cnt = r_cnt;
    assign bus.sr_err     = r_err;
endmodule

// File: tb/tb_jkff_bank.sv
// Scoreboard bench for jkff_bank: directed scenarios then random traffic,
// each cycle's expected state produced by a lane-wise reference model.
module tb_jkff_bank;
    localparam int              W   = 4;
    localparam int              CW  = 4;
    localparam logic [W-1:0]    RV  = 4'b1010;
    localparam int              MAX = (1 << CW) - 1;

    typedef struct packed {
        logic [W-1:0]  q;
        logic [W-1:0]  rise;
        logic [W-1:0]  fall;
        logic [CW-1:0] cnt;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // model state
    logic [W-1:0] m_q;
    int           m_cnt;
    logic         m_err;

    jkff_bank_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    jkff_bank #(.WIDTH(W), .RESET_VAL(RV), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic e, input logic [1:0] md,
                        input logic [W-1:0] jj, input logic [W-1:0] kk,
                        input logic clr);
        logic [W-1:0] nq;
        exp_t         x;
        int           chg;
        logic         bad;
        @(negedge clk);
        #1;
        rst         = r;
        bus.en      = e;
        bus.mode    = md;
        bus.j       = jj;
        bus.k       = kk;
        bus.err_clr = clr;
        x   = '0;
        nq  = m_q;
        chg = 0;
        bad = 1'b0;
        if (r) begin
            m_q   = RV;
            m_cnt = 0;
            m_err = 1'b0;
        end else begin
            if (e) begin
                for (int i = 0; i < W; i++) begin
                    case (md)
                        2'd0: begin
                            if (jj[i] && kk[i]) nq[i] = ~m_q[i];
                            else if (jj[i])     nq[i] = 1'b1;
                            else if (kk[i])     nq[i] = 1'b0;
                        end
                        2'd1: if (jj[i]) nq[i] = ~m_q[i];
                        2'd2: nq[i] = jj[i];
                        default: begin
                            if (jj[i] && !kk[i])      nq[i] = 1'b1;
                            else if (!jj[i] && kk[i]) nq[i] = 1'b0;
                            else if (jj[i] && kk[i])  bad = 1'b1;
                        end
                    endcase
                end
            end
            for (int i = 0; i < W; i++) begin
                if (!m_q[i] && nq[i]) x.rise[i] = 1'b1;
                if (m_q[i] && !nq[i]) x.fall[i] = 1'b1;
                if (m_q[i] != nq[i])  chg++;
            end
            m_cnt = (m_cnt + chg > MAX) ? MAX : m_cnt + chg;
            if (bad)      m_err = 1'b1;
            else if (clr) m_err = 1'b0;
            m_q = nq;
        end
        x.q   = m_q;
        x.cnt = CW'(m_cnt);
        x.err = m_err;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            n_vec++;
            if (bus.q !== x.q || bus.q_n !== ~x.q || bus.rise !== x.rise ||
                bus.fall !== x.fall || bus.toggle_cnt !== x.cnt ||
                bus.sr_err !== x.err) begin
                n_miss++;
                $display("FAIL vec%0d: got q=%b qn=%b rise=%b fall=%b cnt=%0d err=%b, want q=%b qn=%b rise=%b fall=%b cnt=%0d err=%b",
                         n_vec, bus.q, bus.q_n, bus.rise, bus.fall,
                         bus.toggle_cnt, bus.sr_err, x.q, ~x.q, x.rise,
                         x.fall, x.cnt, x.err);
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.en = 1'b0;
        bus.mode = 2'b00;
        bus.j = '0;
        bus.k = '0;
        bus.err_clr = 1'b0;
        m_q = RV;
        m_cnt = 0;
        m_err = 1'b0;
        // reset then JK truth table
        step(1, 0, 2'b00, 4'b0000, 4'b0000, 0);
        step(0, 1, 2'b00, 4'b0011, 4'b0101, 0);
        // clear to zero, then T mode with enable gating
        step(0, 1, 2'b10, 4'b0000, 4'b0000, 0);
        for (int i = 0; i < 4; i++)
            step(0, (i % 2 == 0), 2'b01, 4'b1111, 4'b0000, 0);
        // D mode repeated
        step(0, 1, 2'b10, 4'b0110, 4'b0000, 0);
        step(0, 1, 2'b10, 4'b0110, 4'b0000, 0);
        // SR illegal, clear racing set, then legal clear
        step(0, 1, 2'b10, 4'b0000, 4'b0000, 0);
        step(0, 1, 2'b11, 4'b1100, 4'b0110, 0);
        step(0, 1, 2'b11, 4'b1100, 4'b0110, 1);
        step(0, 1, 2'b11, 4'b0000, 4'b0000, 1);
        // illegal SR ignored while disabled
        step(0, 0, 2'b11, 4'b1111, 4'b1111, 0);
        // counter saturation from zero
        step(1, 0, 2'b00, 4'b0000, 4'b0000, 0);
        for (int i = 0; i < 5; i++)
            step(0, 1, 2'b01, 4'b1111, 4'b0000, 0);
        // reset during toggling
        step(0, 1, 2'b11, 4'b1111, 4'b1111, 0);
        step(1, 1, 2'b01, 4'b1111, 4'b0000, 0);
        step(0, 1, 2'b01, 4'b1111, 4'b0000, 0);
        // random traffic
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
                 ($urandom_range(0, 3) == 0));
        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(negedge clk);
        if (sb.size() > 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
